timeset_ctrl: RTL

Time-setting controller for the minute:second clock. It debounces the two board pushbuttons and runs a RUN/SET_MIN/SET_SEC state machine. While setting, it edits BCD minute and second values, then writes them back to the two `cnt60` counters through a one-cycle load strobe. It also gates the 1 Hz count enable and drives per-field blink blanking for the 7-segment decoders.

---
 rtl/timeset_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/timeset_ctrl.sv
// Time-setting controller: debounced MODE/UP buttons drive a RUN/SET_MIN/SET_SEC
// editor for BCD minute:second values with a load strobe and blink blanking.
module timeset_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BLINK_CYCLES    = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nBTN_MODE,
  input  logic       nBTN_UP,
  input  logic [2:0] curminup,
  input  logic [3:0] curminlow,
  input  logic [2:0] cursecup,
  input  logic [3:0] curseclow,
  output logic       run_en,
  output logic       setting,
  output logic       ld,
  output logic [2:0] ldminup,
  output logic [3:0] ldminlow,
  output logic [2:0] ldsecup,
  output logic [3:0] ldseclow,
  output logic       blankmin,
  output logic       blanksec
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, SET_MIN, SET_SEC} state_t;

  // Bit 0 is MODE, bit 1 is UP; all levels are active-low (1 = released).
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    evt;
  logic [DW-1:0] db_cnt [2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      evt   <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {nBTN_UP, nBTN_MODE};
      sync2 <= sync1;
      deb_d <= deb;
      evt   <= deb_d & ~deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic mode_evt;
  logic up_evt;
  assign mode_evt = evt[0];
  assign up_evt   = evt[1];

  // Increment a BCD mm or ss field, wrapping 59 -> 00; any invalid field resets to 00.
  function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] units);
    if (tens > 3'd5 || units > 4'd9) return '0;
    if (units == 4'd9) return (tens == 3'd5) ? 7'd0 : {tens + 3'd1, 4'd0};
    return {tens, units + 4'd1};
  endfunction

  state_t        state;
  state_t        nxt_state;
  logic [6:0]    nxt_min;
  logic [6:0]    nxt_sec;
  logic          do_ld;
  logic          up_hit;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] nxt_blink_cnt;
  logic          phase;
  logic          nxt_phase;

  always_comb begin
    nxt_state = state;
    nxt_min   = {ldminup, ldminlow};
    nxt_sec   = {ldsecup, ldseclow};
    do_ld     = 1'b0;
    up_hit    = 1'b0;
    // MODE is tested first in every state so a simultaneous UP is dropped.
    case (state)
      RUN: begin
        if (mode_evt) begin
          nxt_state = SET_MIN;
          nxt_min   = {curminup, curminlow};
          nxt_sec   = {cursecup, curseclow};
        end
      end
      SET_MIN: begin
        if (mode_evt) begin
          nxt_state = SET_SEC;
        end else if (up_evt) begin
          nxt_min = bcd_inc(ldminup, ldminlow);
          up_hit  = 1'b1;
        end
      end
      SET_SEC: begin
        if (mode_evt) begin
          nxt_state = RUN;
          do_ld     = 1'b1;
        end else if (up_evt) begin
          nxt_sec = bcd_inc(ldsecup, ldseclow);
          up_hit  = 1'b1;
        end
      end
      default: nxt_state = RUN;
    endcase

    // Restarting the blink on edits keeps the freshly changed field visible.
    if (nxt_state != state || up_hit) begin
      nxt_blink_cnt = '0;
      nxt_phase     = 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      nxt_blink_cnt = '0;
      nxt_phase     = ~phase;
    end else begin
      nxt_blink_cnt = blink_cnt + 1'b1;
      nxt_phase     = phase;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      blink_cnt <= '0;
      phase     <= 1'b0;
      run_en    <= 1'b1;
      setting   <= 1'b0;
      ld        <= 1'b0;
      ldminup   <= '0;
      ldminlow  <= '0;
      ldsecup   <= '0;
      ldseclow  <= '0;
      blankmin  <= 1'b0;
      blanksec  <= 1'b0;
    end else begin
      state     <= nxt_state;
      blink_cnt <= nxt_blink_cnt;
      phase     <= nxt_phase;
      run_en    <= (nxt_state == RUN);
      setting   <= (nxt_state != RUN);
      ld        <= do_ld;
      ldminup   <= nxt_min[6:4];
      ldminlow  <= nxt_min[3:0];
      ldsecup   <= nxt_sec[6:4];
      ldseclow  <= nxt_sec[3:0];
      blankmin  <= (nxt_state == SET_MIN) && nxt_phase;
      blanksec  <= (nxt_state == SET_SEC) && nxt_phase;
    end
  end

endmodule
